mult_share_arb: RTL and testbench



---
 rtl/mult_share_pkg.sv | 48 ++++
 rtl/mult_rr_arb.sv | 44 ++++
 rtl/wallace_gen.sv | 36 +++
 rtl/mult_share_arb.sv | 126 ++++++++++++
 tb/tb_mult_share_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// The optional grant statistics are enabled with MULT_SHARE_ARB_STATS_EN.
package mult_share_pkg;

    localparam int STATS_W = 16;
    localparam int MAX_R   = 8;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // First set bit at or after ptr, wrapping within the first r bits.
    function automatic rr_pick_t rr_pick(input logic [MAX_R-1:0] valid,
                                         input logic [MAX_IDW-1:0] ptr,
                                         input int r);
        rr_pick_t   pick;
        logic [3:0] pos;
        pick = '0;
        pos  = '0;
        for (int k = MAX_R - 1; k >= 0; k--) begin
            if (k < r) begin
                pos = {1'b0, ptr} + 4'(k);
                if (pos >= 4'(r)) begin
                    pos = pos - 4'(r);
                end
                if (valid[pos[MAX_IDW-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = pos[MAX_IDW-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_rr_arb.sv
// Round-robin pointer and grant selection for the shared multiplier.
module mult_rr_arb
    import mult_share_pkg::*;
#(
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    input  logic           accept,
    output logic           grant_found,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0]     ptr_reg;
    logic [MAX_R-1:0]   valid_ext;
    logic [MAX_IDW-1:0] ptr_ext;
    rr_pick_t           pick;

    always_comb begin
        valid_ext        = '0;
        valid_ext[R-1:0] = req_valid;
    end

    assign ptr_ext     = MAX_IDW'(ptr_reg);
    assign pick        = rr_pick(valid_ext, ptr_ext, R);
    assign grant_found = pick.found;
    assign grant_idx   = IDW'(pick.idx);

    // Pointer moves just past the winner so it becomes lowest priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (accept) begin
            if (int'(grant_idx) == R - 1) begin
                ptr_reg <= '0;
            end else begin
                ptr_reg <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wallace_gen.sv
// Signed N x W multiplier built from partial products; result truncated to N+W-1 bits.
module wallace_gen #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [N+W-2:0] prod
);

    localparam int P_W = N + W - 1;

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] pp [W];

    assign a_ext = {{(W-1){a[N-1]}}, a};

    // The top bit of b carries negative weight, so its row is negated.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pp
            if (gi == W - 1) begin : g_neg
                assign pp[gi] = b[gi] ? (~(a_ext << gi) + 1'b1) : '0;
            end else begin : g_pos
                assign pp[gi] = b[gi] ? (a_ext << gi) : '0;
            end
        end
    endgenerate

    always_comb begin
        prod = '0;
        for (int i = 0; i < W; i++) begin
            prod = prod + pp[i];
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// One signed multiplier shared by R requesters: RR arbiter -> S1 operands -> S2 product.
// Optional per-requester accept counters are enabled with MULT_SHARE_ARB_STATS_EN.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter  int R   = 4,
    parameter  int N   = 8,
    parameter  int W   = 4,
    localparam int IDW = (clog2(R) > 1) ? clog2(R) : 1,
    localparam int P_W = N + W - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [P_W-1:0] rsp_prod,
    output logic           busy
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [R*STATS_W-1:0] grant_cnt
`endif
);

    logic           s1_valid_reg;
    logic [N-1:0]   s1_a_reg;
    logic [W-1:0]   s1_b_reg;
    logic [IDW-1:0] s1_id_reg;
    logic           s2_load;
    logic           s1_free;
    logic           accept;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [R-1:0]   grant_onehot;
    logic [P_W-1:0] mult_prod;

    assign s2_load = s1_valid_reg && (!rsp_valid || rsp_ready);
    assign s1_free = !s1_valid_reg || s2_load;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_found && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Ready is forced low while reset is held, even though S1 already reads empty.
    assign req_ready = (rst_n && s1_free) ? (grant_onehot & req_valid) : '0;
    assign accept    = |req_ready;
    assign busy      = s1_valid_reg || rsp_valid;

    mult_rr_arb #(
        .R   (R),
        .IDW (IDW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .accept      (accept),
        .grant_found (grant_found),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= req_a[int'(grant_idx) * N +: N];
            s1_b_reg     <= req_b[int'(grant_idx) * W +: W];
            s1_id_reg    <= grant_idx;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    wallace_gen #(
        .N (N),
        .W (W)
    ) u_mult (
        .a    (s1_a_reg),
        .b    (s1_b_reg),
        .prod (mult_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id_reg;
            rsp_prod  <= mult_prod;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    // A clear wins over an accept landing in the same cycle.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_stats
            logic [STATS_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (stats_clr) begin
                    cnt_reg <= '0;
                end else if (req_ready[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign grant_cnt[gi*STATS_W +: STATS_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: random and directed traffic against a queue-based model.
module tb_mult_share_arb;

    localparam int R   = 4;
    localparam int N   = 8;
    localparam int W   = 4;
    localparam int IDW = 2;
    localparam int P_W = N + W - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [P_W-1:0] rsp_prod;
    logic           busy;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic           stats_clr;
    logic [R*16-1:0] grant_cnt;
`endif

    logic [R-1:0]          vld;
    logic signed [N-1:0]   av [R];
    logic signed [W-1:0]   bv [R];

    assign req_valid = vld;
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_pack
            assign req_a[gi*N +: N] = av[gi];
            assign req_b[gi*W +: W] = bv[gi];
        end
    endgenerate

    mult_share_arb #(.R(R), .N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
`ifdef MULT_SHARE_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [P_W-1:0] prod;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb [$];
    int   acc_count [R];
    int   seen [R];
    int   cnt_m [R];
    int   items;
    int   ptr_m;
    int   gexp;
    int   pop;
    logic [R-1:0] exp_rdy;
    logic [R-1:0] acc;
    logic         hold_pending;
    logic [IDW-1:0] held_id;
    logic [P_W-1:0] held_prod;
    exp_t         e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Signed product of the operands, wrapped to the product width.
    function automatic logic [P_W-1:0] ref_mul(input int a, input int b);
        int p;
        p = a * b;
        return P_W'(p);
    endfunction

    function automatic int rr_expect(input logic [R-1:0] v, input int p);
        for (int k = 0; k < R; k++) begin
            if (v[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    task automatic new_ops(input int i);
        av[i] = N'($urandom);
        bv[i] = W'($urandom);
        case ($urandom_range(0, 7))
            0: begin av[i] = -128; bv[i] = -8; end
            1: begin av[i] = 127;  bv[i] = 7;  end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop valid on every requester that was accepted since the last look.
    task automatic collect(output int n_new);
        n_new = 0;
        for (int i = 0; i < R; i++) begin
            if (acc_count[i] != seen[i]) begin
                seen[i] = acc_count[i];
                vld[i]  = 1'b0;
                n_new++;
            end
        end
    endtask

    task automatic wait_all(input string name);
        int n;
        int budget;
        budget = 40;
        while (vld != '0 && budget > 0) begin
            tick();
            collect(n);
            budget--;
        end
        if (vld != '0) chk({name, "_accept_timeout"}, 32'(vld), 32'(0));
    endtask

    task automatic drain(input string name);
        int budget;
        vld       = '0;
        rsp_ready = 1'b1;
        budget    = 40;
        while ((sb.size() != 0 || busy) && budget > 0) begin
            tick();
            budget--;
        end
        chk({name, "_drain_left"}, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int n;
        int who;
        int nrsp;
        rst_n     = 1'b0;
        vld       = '0;
        rsp_ready = 1'b0;
        items     = 0;
        ptr_m     = 0;
        hold_pending = 1'b0;
        for (int i = 0; i < R; i++) begin
            av[i] = '0; bv[i] = '0;
            acc_count[i] = 0; seen[i] = 0; cnt_m[i] = 0;
        end
`ifdef MULT_SHARE_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        fork
            forever begin : monitor
                @(negedge clk);
                if (!rst_n) begin
                    sb.delete();
                    items = 0;
                    ptr_m = 0;
                    hold_pending = 1'b0;
                    for (int i = 0; i < R; i++) cnt_m[i] = 0;
                end else begin
                    gexp    = rr_expect(vld, ptr_m);
                    exp_rdy = '0;
                    if (gexp >= 0 && !(items == 2 && !rsp_ready)) exp_rdy = R'(1 << gexp);
                    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                    chk("busy", 32'(busy), 32'(items != 0));
                    if (hold_pending) begin
                        chk("hold_valid", 32'(rsp_valid), 32'(1));
                        chk("hold_id", 32'(rsp_id), 32'(held_id));
                        chk("hold_prod", 32'(rsp_prod), 32'(held_prod));
                    end
                    pop = 0;
                    if (rsp_valid && rsp_ready) begin
                        pop = 1;
                        if (sb.size() == 0) begin
                            chk("spurious_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_id", 32'(rsp_id), 32'(e.id));
                            chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                            $display("rsp id=%0d prod=0x%03h", rsp_id, rsp_prod);
                        end
                    end
                    hold_pending = rsp_valid && !rsp_ready;
                    held_id      = rsp_id;
                    held_prod    = rsp_prod;
                    acc = vld & req_ready;
                    for (int i = 0; i < R; i++) begin
                        if (acc[i]) begin
                            e.id   = i;
                            e.prod = ref_mul(int'(av[i]), int'(bv[i]));
                            sb.push_back(e);
                            acc_count[i]++;
                            cnt_m[i]++;
                            ptr_m = (i + 1) % R;
                        end
                    end
                    items = items + ((acc != '0) ? 1 : 0) - pop;
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog: actual=timeout required=finish");
                $fatal(1, "bench timed out");
            end
        join_none

        // Reset state, with requests already pending
        repeat (2) @(posedge clk);
        #1;
        vld = '1;
        for (int i = 0; i < R; i++) new_ops(i);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_prod", 32'(rsp_prod), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));

        // Round robin with all requesters busy: 0,1,2,3,0 back to back
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            who = -1;
            n   = 0;
            for (int i = 0; i < R; i++) begin
                if (acc_count[i] != seen[i]) begin
                    seen[i] = acc_count[i];
                    who = i;
                    n++;
                    new_ops(i);
                end
            end
            chk("rr_grant", 32'(who), 32'(c % R));
            chk("rr_one_per_cycle", 32'(n), 32'(1));
        end
        drain("rr");

        // Single request with the latency checked edge by edge
        vld[2] = 1'b1; av[2] = 25; bv[2] = -3;
        wait_all("single");
        chk("single_s1_only", 32'(rsp_valid), 32'(0));
        tick();
        chk("single_valid", 32'(rsp_valid), 32'(1));
        chk("single_id", 32'(rsp_id), 32'(2));
        chk("single_prod", 32'(rsp_prod), 32'(11'h7B5));
        drain("single");

        // Backpressure: two accepted, third must wait
        rsp_ready = 1'b0;
        vld[0] = 1'b1; new_ops(0);
        vld[1] = 1'b1; new_ops(1);
        vld[3] = 1'b1; new_ops(3);
        nrsp = 0;
        for (int c = 0; c < 10 && nrsp < 2; c++) begin
            tick();
            collect(n);
            nrsp += n;
        end
        chk("bp_two_accepts", 32'(nrsp), 32'(2));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_ready_low", 32'(req_ready), 32'(0));
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        end
        rsp_ready = 1'b1;
        wait_all("bp");
        drain("bp");

        // Overflow corner and largest positive product
        vld[0] = 1'b1; av[0] = -128; bv[0] = -8;
        vld[1] = 1'b1; av[1] = 127;  bv[1] = 7;
        nrsp = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            collect(n);
            if (rsp_valid && rsp_ready) begin
                nrsp++;
                if (rsp_id == 0) chk("ovf_min_prod", 32'(rsp_prod), 32'(11'h400));
                else             chk("ovf_max_prod", 32'(rsp_prod), 32'(11'd889));
            end
        end
        chk("ovf_rsp_count", 32'(nrsp), 32'(2));
        drain("ovf");

        // Random traffic with random downstream stalls
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < R; i++) begin
                if (acc_count[i] != seen[i]) begin
                    seen[i] = acc_count[i];
                    vld[i]  = 1'($urandom_range(0, 1));
                    new_ops(i);
                end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    new_ops(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        wait_all("rand");
        drain("rand");

        // Asynchronous reset in the middle of a burst
        vld = '1;
        for (int i = 0; i < R; i++) new_ops(i);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < R; i++) begin
                if (acc_count[i] != seen[i]) begin
                    seen[i] = acc_count[i];
                    new_ops(i);
                end
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_req_ready", 32'(req_ready), 32'(0));
        repeat (2) @(posedge clk);
        for (int i = 0; i < R; i++) seen[i] = acc_count[i];
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_first_grant", 32'(req_ready), 32'(4'b0001));
        wait_all("arst");
        drain("arst");

`ifdef MULT_SHARE_ARB_STATS_EN
        for (int i = 0; i < R; i++) begin
            chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(cnt_m[i]));
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < R; i++) begin
            chk("grant_cnt_clr", 32'(grant_cnt[i*16 +: 16]), 32'(0));
        end
`endif

        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
